// File: rtl/pong_pkg.sv
// Shared game-flow encoding, screen geometry and the paddle step/clamp helper.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned TOP_MARGIN    = 25;
  localparam int unsigned PADDLE_H      = 72;
  localparam int unsigned Y_CENTER      = 191;
  localparam int unsigned Y_MAX_DEFAULT = SCREEN_HEIGHT - TOP_MARGIN - PADDLE_H;

  // One paddle move: up-only or down-only steps with clamping, anything else holds.
  // The sum is formed one bit wider so a large y never wraps past the clamp.
  function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                             input logic       up,
                                             input logic       dn,
                                             input logic [9:0] step,
                                             input logic [9:0] y_max);
    logic [10:0] w_sum;
    w_sum       = {1'b0, y} + {1'b0, step};
    paddle_next = y;
    if (up && !dn)
      paddle_next = (y >= step) ? (y - step) : '0;
    else if (dn && !up)
      paddle_next = (w_sum <= {1'b0, y_max}) ? w_sum[9:0] : y_max;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stable-sample counter.
// The clean output flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with it; any sample that agrees restarts the count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_clean;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= raw;
      r_sync1 <= r_sync0;
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (r_sync1 == r_clean) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_clean <= r_sync1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign clean = r_clean;

endmodule

// File: rtl/pong_input_ctrl.sv
// Pong input front end: button debouncing, 60 Hz refresh tick, paddle motion
// and the game-flow FSM feeding ball_controller.
module pong_input_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 416667,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PADDLE_STEP     = 4,
  parameter int unsigned Y_MAX           = Y_MAX_DEFAULT,
  parameter int unsigned SERVE_TICKS     = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_p1_up,
  input  logic       btn_p1_dn,
  input  logic       btn_p2_up,
  input  logic       btn_p2_dn,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       refresh_tick,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       game_active,
  output logic       ball_reset,
  output logic [2:0] state
);

  localparam int unsigned      TW        = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam int unsigned      DW        = $clog2(SERVE_TICKS + 1);
  localparam logic [DW-1:0]    CD_LAST   = DW'(SERVE_TICKS - 1);
  localparam logic [9:0]       STEP10    = 10'(PADDLE_STEP);
  localparam logic [9:0]       YMAX10    = 10'(Y_MAX);
  localparam logic [9:0]       CENTER10  = 10'(Y_CENTER);

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_p1_up;
  logic          w_p1_dn;
  logic          w_p2_up;
  logic          w_p2_dn;
  logic          w_start;
  logic          r_start_prev;
  logic          w_start_evt;
  state_t        r_state;
  logic [DW-1:0] r_cd_cnt;
  logic [9:0]    r_p1_y;
  logic [9:0]    r_p2_y;
  logic          r_game_active;
  logic          r_ball_reset;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_up (
    .clk(clk), .reset(reset), .raw(btn_p1_up), .clean(w_p1_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_dn (
    .clk(clk), .reset(reset), .raw(btn_p1_dn), .clean(w_p1_dn));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_up (
    .clk(clk), .reset(reset), .raw(btn_p2_up), .clean(w_p2_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_dn (
    .clk(clk), .reset(reset), .raw(btn_p2_dn), .clean(w_p2_dn));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .raw(btn_start), .clean(w_start));

  // Free-running refresh divider; the tick is decoded from the counter value
  // so it drops together with the counter on an asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tick_cnt <= '0;
    else if (r_tick_cnt == TICK_LAST)
      r_tick_cnt <= '0;
    else
      r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Delay the debounced start button for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_start_prev <= 1'b0;
    else
      r_start_prev <= w_start;
  end

  assign w_start_evt = w_start & ~r_start_prev;

  // Game-flow FSM with paddle datapath; game_active is written alongside each
  // state change so it always mirrors the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cd_cnt      <= '0;
      r_p1_y        <= CENTER10;
      r_p2_y        <= CENTER10;
      r_game_active <= 1'b0;
      r_ball_reset  <= 1'b0;
    end else begin
      r_ball_reset <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_evt) begin
            r_state      <= ST_COUNTDOWN;
            r_ball_reset <= 1'b1;
            r_cd_cnt     <= '0;
            r_p1_y       <= CENTER10;
            r_p2_y       <= CENTER10;
          end
        end
        ST_COUNTDOWN: begin
          if (w_tick) begin
            if (r_cd_cnt == CD_LAST) begin
              r_state       <= ST_PLAY;
              r_game_active <= 1'b1;
            end else begin
              r_cd_cnt <= r_cd_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (w_tick) begin
            r_p1_y <= paddle_next(r_p1_y, w_p1_up, w_p1_dn, STEP10, YMAX10);
            r_p2_y <= paddle_next(r_p2_y, w_p2_up, w_p2_dn, STEP10, YMAX10);
          end
          if (game_over) begin
            r_state       <= ST_OVER;
            r_game_active <= 1'b0;
          end else if (w_start_evt) begin
            r_state       <= ST_PAUSE;
            r_game_active <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (w_start_evt) begin
            r_state       <= ST_PLAY;
            r_game_active <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_game_active <= 1'b0;
        end
      endcase
    end
  end

  assign refresh_tick = w_tick;
  assign paddle1_y    = r_p1_y;
  assign paddle2_y    = r_p2_y;
  assign game_active  = r_game_active;
  assign ball_reset   = r_ball_reset;
  assign state        = r_state;

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Directed bench for pong_input_ctrl with a short tick, debounce and serve delay.
module tb_pong_input_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_p1_up;
  logic       btn_p1_dn;
  logic       btn_p2_up;
  logic       btn_p2_dn;
  logic       btn_start;
  logic       game_over;
  logic       refresh_tick;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       game_active;
  logic       ball_reset;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int br_count = 0;

  pong_input_ctrl #(
    .TICK_DIV(10),
    .DEBOUNCE_CYCLES(4),
    .PADDLE_STEP(4),
    .Y_MAX(383),
    .SERVE_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_p1_up(btn_p1_up),
    .btn_p1_dn(btn_p1_dn),
    .btn_p2_up(btn_p2_up),
    .btn_p2_dn(btn_p2_dn),
    .btn_start(btn_start),
    .game_over(game_over),
    .refresh_tick(refresh_tick),
    .paddle1_y(paddle1_y),
    .paddle2_y(paddle2_y),
    .game_active(game_active),
    .ball_reset(ball_reset),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ball_reset pulses seen at sample points.
  always @(negedge clk) if (ball_reset === 1'b1) br_count++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stay on negedges until refresh_tick is seen high (bounded).
  task automatic wait_tick();
    bit ok = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (refresh_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("tick_wait", {31'd0, ok}, 1);
  endtask

  // Hold start for 6 cycles, release, land on the cycle after the FSM reacts.
  task automatic press_start();
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    btn_start = 1'b0;
    @(negedge clk);
  endtask

  // From the first COUNTDOWN cycle, count three ticks and enter PLAY.
  task automatic run_countdown();
    int ticks = 0;
    for (int i = 0; i < 40; i++) begin
      if (refresh_tick === 1'b1) ticks++;
      if (ticks == 3) break;
      @(negedge clk);
    end
    chk("cd_ticks", ticks, 3);
    chk("cd_state_before", {29'd0, state}, 1);
    @(negedge clk);
    chk("play_state", {29'd0, state}, 2);
    chk("play_active", {31'd0, game_active}, 1);
  endtask

  initial begin
    int pulses;
    int first_k;
    logic [9:0] exp1;
    logic [9:0] exp2;

    reset = 1'b1;
    btn_p1_up = 1'b0; btn_p1_dn = 1'b0; btn_p2_up = 1'b0; btn_p2_dn = 1'b0;
    btn_start = 1'b0; game_over = 1'b0;

    @(negedge clk);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_p1", {22'd0, paddle1_y}, 191);
    chk("rst_p2", {22'd0, paddle2_y}, 191);
    chk("rst_active", {31'd0, game_active}, 0);
    chk("rst_ballrst", {31'd0, ball_reset}, 0);
    chk("rst_tick", {31'd0, refresh_tick}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Tick cadence: first pulse after 9 edges, then every 10.
    pulses = 0;
    first_k = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (refresh_tick === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("tick_pulses", pulses, 3);
    chk("tick_first", first_k, 9);

    // 3-cycle glitch on start must be rejected.
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_state", {29'd0, state}, 0);
    chk("glitch_br", br_count, 0);

    // Start a game.
    press_start();
    chk("start_state", {29'd0, state}, 1);
    chk("start_br", {31'd0, ball_reset}, 1);
    chk("start_active", {31'd0, game_active}, 0);
    run_countdown();
    chk("start_br_count", br_count, 1);

    // p1 up from 191 down to the top clamp.
    btn_p1_up = 1'b1;
    exp1 = 10'd191;
    for (int t = 0; t < 50; t++) begin
      wait_tick();
      @(negedge clk);
      exp1 = (exp1 >= 10'd4) ? exp1 - 10'd4 : 10'd0;
      chk("p1_up", {22'd0, paddle1_y}, {22'd0, exp1});
    end
    chk("p1_floor", {22'd0, paddle1_y}, 0);
    chk("p2_idle", {22'd0, paddle2_y}, 191);

    // p2 down to the bottom clamp.
    btn_p1_up = 1'b0;
    btn_p2_dn = 1'b1;
    exp2 = 10'd191;
    for (int t = 0; t < 50; t++) begin
      wait_tick();
      @(negedge clk);
      exp2 = (exp2 + 10'd4 <= 10'd383) ? exp2 + 10'd4 : 10'd383;
      chk("p2_dn", {22'd0, paddle2_y}, {22'd0, exp2});
    end
    chk("p2_ceiling", {22'd0, paddle2_y}, 383);
    chk("p1_hold", {22'd0, paddle1_y}, 0);

    // Both directions on both paddles: hold.
    btn_p1_up = 1'b1; btn_p1_dn = 1'b1; btn_p2_up = 1'b1;
    repeat (3) begin
      wait_tick();
      @(negedge clk);
    end
    chk("both_p1", {22'd0, paddle1_y}, 0);
    chk("both_p2", {22'd0, paddle2_y}, 383);
    btn_p1_up = 1'b0; btn_p1_dn = 1'b0; btn_p2_up = 1'b0; btn_p2_dn = 1'b0;
    wait_tick();
    @(negedge clk);

    // Pause: paddles frozen while ticks keep running.
    press_start();
    chk("pause_state", {29'd0, state}, 3);
    chk("pause_active", {31'd0, game_active}, 0);
    btn_p2_up = 1'b1;
    repeat (2) begin
      wait_tick();
      @(negedge clk);
    end
    chk("pause_p2", {22'd0, paddle2_y}, 383);
    chk("pause_state2", {29'd0, state}, 3);
    press_start();
    chk("resume_state", {29'd0, state}, 2);
    chk("resume_active", {31'd0, game_active}, 1);
    wait_tick();
    @(negedge clk);
    chk("resume_p2", {22'd0, paddle2_y}, 379);
    btn_p2_up = 1'b0;
    repeat (8) @(negedge clk);

    // game_over and start_evt together: game_over wins.
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    btn_start = 1'b0;
    game_over = 1'b1;
    @(negedge clk);
    chk("over_state", {29'd0, state}, 4);
    chk("over_active", {31'd0, game_active}, 0);
    repeat (10) @(negedge clk);
    chk("over_hold", {29'd0, state}, 4);
    press_start();
    chk("restart_state", {29'd0, state}, 1);
    chk("restart_br", {31'd0, ball_reset}, 1);
    chk("restart_p1", {22'd0, paddle1_y}, 191);
    chk("restart_p2", {22'd0, paddle2_y}, 191);
    @(negedge clk);
    chk("restart_go_ignored", {29'd0, state}, 1);
    chk("restart_br_low", {31'd0, ball_reset}, 0);
    chk("restart_br_count", br_count, 2);
    game_over = 1'b0;

    // Async reset during COUNTDOWN.
    #2 reset = 1'b1;
    #1;
    chk("arst_cd_state", {29'd0, state}, 0);
    chk("arst_cd_active", {31'd0, game_active}, 0);
    chk("arst_cd_br", {31'd0, ball_reset}, 0);
    chk("arst_cd_p1", {22'd0, paddle1_y}, 191);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Async reset during a paddle move, taken while refresh_tick is high.
    press_start();
    chk("again_state", {29'd0, state}, 1);
    run_countdown();
    btn_p1_dn = 1'b1;
    repeat (2) begin
      wait_tick();
      @(negedge clk);
    end
    chk("move_p1", {22'd0, paddle1_y}, 199);
    wait_tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_mv_tick", {31'd0, refresh_tick}, 0);
    chk("arst_mv_p1", {22'd0, paddle1_y}, 191);
    chk("arst_mv_p2", {22'd0, paddle2_y}, 191);
    chk("arst_mv_state", {29'd0, state}, 0);
    chk("arst_mv_active", {31'd0, game_active}, 0);
    btn_p1_dn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
